// File: rtl/resp_packetizer_if.sv
// Upstream request / downstream byte-stream bundle for resp_packetizer.
// slave: packetizer side. master: the side driving requests and consuming bytes.
interface resp_packetizer_if #(
  parameter int unsigned MAX_BYTES_P = 8
);
  logic [7:0]               opcode_i;
  logic [8*MAX_BYTES_P-1:0] data_i;
  logic [3:0]               nbytes_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [7:0]               data_o;
  logic                     valid_o;
  logic                     ready_i;
  logic                     done_o;

  modport slave (
    input  opcode_i, data_i, nbytes_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, done_o
  );

  modport master (
    output opcode_i, data_i, nbytes_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, done_o
  );
endinterface

// File: rtl/resp_packetizer.sv
// Serializes one result (opcode + up to MAX_BYTES_P payload bytes) into a
// framed response: opcode, reserved, len LSB, len MSB, payload (LSB first).
// len counts header and payload bytes.
module resp_packetizer #(
  parameter int unsigned MAX_BYTES_P = 8,
  parameter logic [7:0]  RSV_BYTE_P  = 8'h00
) (
  input logic clk,
  input logic rst,
  resp_packetizer_if.slave bus
);

  localparam int unsigned DW = 8 * MAX_BYTES_P;

  // state names the byte currently presented on data_o
  typedef enum logic [2:0] {IDLE, OP, RSV, LEN_LSB, LEN_MSB, PAYLOAD} state_t;

  state_t          state, state_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   shreg_q, shreg_d;

  logic            ready;
  logic            hs;
  logic [3:0]      cnt_clamped;
  logic [15:0]     len;

  assign ready       = (state == IDLE) && !rst;
  assign hs          = valid_q && bus.ready_i;
  assign cnt_clamped = ({28'd0, bus.nbytes_i} > MAX_BYTES_P) ? 4'(MAX_BYTES_P) : bus.nbytes_i;
  assign len         = 16'(cnt_q) + 16'd4;

  assign bus.ready_o = ready;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.done_o  = done_q;

  // State and output registers; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state   <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next state and next registered output byte.
  // data_o is registered, so each handshake loads the byte of the state
  // being entered; in PAYLOAD cnt_q counts bytes left including the one shown.
  always_comb begin
    state_d = state;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    unique case (state)
      IDLE: begin
        if (bus.valid_i && ready) begin
          state_d = OP;
          data_d  = bus.opcode_i;
          valid_d = 1'b1;
          cnt_d   = cnt_clamped;
          shreg_d = bus.data_i;
        end
      end
      OP: begin
        if (hs) begin
          state_d = RSV;
          data_d  = RSV_BYTE_P;
        end
      end
      RSV: begin
        if (hs) begin
          state_d = LEN_LSB;
          data_d  = len[7:0];
        end
      end
      LEN_LSB: begin
        if (hs) begin
          state_d = LEN_MSB;
          data_d  = len[15:8];
        end
      end
      LEN_MSB: begin
        if (hs) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = PAYLOAD;
            data_d  = shreg_q[7:0];
            shreg_d = shreg_q >> 8;
          end
        end
      end
      PAYLOAD: begin
        if (hs) begin
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            data_d  = shreg_q[7:0];
            shreg_d = shreg_q >> 8;
            cnt_d   = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_resp_packetizer.sv
// Self-checking bench for resp_packetizer: directed scenarios plus random
// packets checked against a frame-level reference model.
module tb_resp_packetizer;

  logic clk;
  logic rst;

  resp_packetizer_if #(.MAX_BYTES_P(8)) bus ();

  resp_packetizer #(
    .MAX_BYTES_P(8),
    .RSV_BYTE_P (8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int  vcycles, rlow, nstall;
  bit  done_ok, stall_ok, rdy_at_done;

  // Reference frame: opcode, reserved, length (header + clamped payload), payload LSB first
  function automatic void build_exp(input logic [7:0] op, input logic [63:0] d,
                                    input logic [3:0] nb, input bit append);
    int unsigned m;
    logic [15:0] l;
    if (!append) exp_q.delete();
    m = (nb > 4'd8) ? 8 : int'(nb);
    l = 16'(m + 4);
    exp_q.push_back(op);
    exp_q.push_back(8'h00);
    exp_q.push_back(l[7:0]);
    exp_q.push_back(l[15:8]);
    for (int unsigned i = 0; i < m; i++) exp_q.push_back(d[8*i +: 8]);
  endfunction

  // Issue one request and collect the byte stream until done_o (entered just after a posedge)
  task automatic xfer(input logic [7:0] op, input logic [63:0] d, input logic [3:0] nb, input bit toggle);
    int  n;
    bit  phase, held_valid;
    logic [7:0] held;
    got.delete();
    vcycles = 0; rlow = 0; nstall = 0;
    done_ok = 0; stall_ok = 1; rdy_at_done = 0;
    bus.opcode_i = op; bus.data_i = d; bus.nbytes_i = nb;
    bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ready_o && n < 50);
    tests++;
    if (!bus.ready_o) begin fails++; $display("FAIL xfer_accept_timeout ready_o=%b required=1", bus.ready_o); end
    @(posedge clk); #1;
    bus.valid_i  = 1'b0;
    bus.opcode_i = 8'($urandom);
    bus.data_i   = {$urandom, $urandom};
    bus.nbytes_i = 4'($urandom_range(0, 15));
    phase = 1'b1; held_valid = 1'b0; held = '0;
    for (int c = 0; c < 200; c++) begin
      bus.ready_i = toggle ? phase : 1'b1;
      phase = !phase;
      @(negedge clk);
      if (held_valid && (bus.data_o !== held || bus.valid_o !== 1'b1)) stall_ok = 0;
      if (bus.done_o) begin done_ok = 1; rdy_at_done = bus.ready_o; end
      else if (!bus.ready_o) rlow++;
      if (bus.valid_o) vcycles++;
      if (bus.valid_o && bus.ready_i) got.push_back(bus.data_o);
      if (bus.valid_o && !bus.ready_i) nstall++;
      held_valid = bus.valid_o && !bus.ready_i;
      held = bus.data_o;
      @(posedge clk); #1;
      if (done_ok) break;
    end
    bus.ready_i = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    bus.opcode_i = '0; bus.data_i = '0; bus.nbytes_i = '0;
    @(negedge clk);
    tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", bus.valid_o); end
    tests++; if (bus.data_o !== 8'h00) begin fails++; $display("FAIL rst_data got=%02h exp=00", bus.data_o); end
    tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL rst_done got=%b exp=0", bus.done_o); end
    tests++; if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b exp=0", bus.ready_o); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL post_rst_ready got=%b exp=1", bus.ready_o); end
    tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL post_rst_valid got=%b exp=0", bus.valid_o); end
    tests++; if (bus.data_o !== 8'h00) begin fails++; $display("FAIL post_rst_data got=%02h exp=00", bus.data_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    build_exp(8'h01, 64'h00000000_DEADBEEF, 4'd4, 0);
    xfer(8'h01, 64'h00000000_DEADBEEF, 4'd4, 0);
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL basic_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL basic_byte%0d got=%02h exp=%02h", i, got[i], exp_q[i]); end
    end
    tests++; if (!done_ok) begin fails++; $display("FAIL basic_done got=0 exp=1"); end
    tests++; if (!rdy_at_done) begin fails++; $display("FAIL basic_ready_at_done got=0 exp=1"); end
    tests++; if (rlow != 8) begin fails++; $display("FAIL basic_ready_low_cycles got=%0d exp=8", rlow); end
    tests++; if (vcycles != 8) begin fails++; $display("FAIL basic_valid_cycles got=%0d exp=8", vcycles); end
  endtask

  task automatic test_header_only;
    logic [63:0] d;
    d = {$urandom, $urandom};
    build_exp(8'hEC, d, 4'd0, 0);
    xfer(8'hEC, d, 4'd0, 0);
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL hdr_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL hdr_byte%0d got=%02h exp=%02h", i, got[i], exp_q[i]); end
    end
    tests++; if (!done_ok) begin fails++; $display("FAIL hdr_done got=0 exp=1"); end
    tests++; if (vcycles != 4) begin fails++; $display("FAIL hdr_valid_cycles got=%0d exp=4", vcycles); end
  endtask

  task automatic test_full_stall;
    build_exp(8'h7E, 64'h8877665544332211, 4'd8, 0);
    xfer(8'h7E, 64'h8877665544332211, 4'd8, 1);
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL stall_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL stall_byte%0d got=%02h exp=%02h", i, got[i], exp_q[i]); end
    end
    tests++; if (!stall_ok) begin fails++; $display("FAIL stall_hold got=unstable exp=stable"); end
    tests++; if (nstall == 0) begin fails++; $display("FAIL stall_seen got=0 exp=>0"); end
    tests++; if (!done_ok) begin fails++; $display("FAIL stall_done got=0 exp=1"); end
  endtask

  task automatic test_clamp;
    logic [63:0] d;
    d = {$urandom, $urandom};
    build_exp(8'hC3, d, 4'd13, 0);
    xfer(8'hC3, d, 4'd13, 0);
    tests++; if (got.size() != 12) begin fails++; $display("FAIL clamp_count got=%0d exp=12", got.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL clamp_byte%0d got=%02h exp=%02h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    logic [7:0]  op;
    logic [63:0] d;
    logic [3:0]  nb;
    bit          tg;
    for (int p = 0; p < 20; p++) begin
      op = 8'($urandom); d = {$urandom, $urandom};
      nb = 4'($urandom_range(0, 15)); tg = 1'($urandom);
      build_exp(op, d, nb, 0);
      xfer(op, d, nb, tg);
      tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_count got=%0d exp=%0d", p, got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_byte%0d got=%02h exp=%02h", p, i, got[i], exp_q[i]); end
      end
      tests++; if (!done_ok || !stall_ok) begin fails++; $display("FAIL rand%0d_done_stall got=%b%b exp=11", p, done_ok, stall_ok); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] da, db;
    int  bidx, nacc, dones;
    bit  acc, op_seen;
    da = {$urandom, $urandom}; db = {$urandom, $urandom};
    build_exp(8'h31, da, 4'd3, 0);
    build_exp(8'h42, db, 4'd5, 1);
    got.delete();
    bidx = -10; nacc = 0; dones = 0; op_seen = 0;
    bus.ready_i = 1'b1;
    bus.opcode_i = 8'h31; bus.data_i = da; bus.nbytes_i = 4'd3; bus.valid_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.valid_o && bus.ready_i) got.push_back(bus.data_o);
      if (k == bidx + 1) op_seen = bus.valid_o && (bus.data_o === 8'h42);
      if (bus.done_o) dones++;
      acc = bus.ready_o && bus.valid_i;
      @(posedge clk); #1;
      if (acc) begin
        if (nacc == 0) begin
          nacc = 1;
          bus.opcode_i = 8'h42; bus.data_i = db; bus.nbytes_i = 4'd5;
        end else begin
          bidx = k;
          bus.valid_i = 1'b0;
          bus.opcode_i = 8'($urandom); bus.data_i = {$urandom, $urandom};
        end
      end
      if (dones == 2) break;
    end
    bus.valid_i = 1'b0;
    tests++; if (bidx != 8) begin fails++; $display("FAIL b2b_accept_cycle got=%0d exp=8", bidx); end
    tests++; if (!op_seen) begin fails++; $display("FAIL b2b_opcode_follow got=0 exp=1"); end
    tests++; if (dones != 2) begin fails++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_byte%0d got=%02h exp=%02h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] d;
    bit          bad;
    d = {$urandom, $urandom};
    bus.ready_i = 1'b1;
    bus.opcode_i = 8'h5A; bus.data_i = d; bus.nbytes_i = 4'd8; bus.valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    tests++; if (bus.data_o !== d[23:16]) begin fails++; $display("FAIL rstmid_byte2 got=%02h exp=%02h", bus.data_o, d[23:16]); end
    rst = 1'b1;
    #1;
    tests++; if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL rstmid_ready_in_rst got=%b exp=0", bus.ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_valid got=%b exp=0", bus.valid_o); end
    tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL rstmid_done got=%b exp=0", bus.done_o); end
    tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%b exp=1", bus.ready_o); end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.valid_o || bus.done_o) bad = 1;
    end
    tests++; if (bad) begin fails++; $display("FAIL rstmid_tail got=activity exp=quiet"); end
    @(posedge clk); #1;
    d = {$urandom, $urandom};
    build_exp(8'hA6, d, 4'd6, 0);
    xfer(8'hA6, d, 4'd6, 0);
    tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rstmid_next_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid_next_byte%0d got=%02h exp=%02h", i, got[i], exp_q[i]); end
    end
    tests++; if (!done_ok) begin fails++; $display("FAIL rstmid_next_done got=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_header_only();
    test_full_stall();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/resp_packetizer.md
# resp_packetizer

Transmit-side counterpart to the command parser. Accepts one result (opcode, up to 8 payload bytes) from the ALU/echo path and serializes it as a framed response packet onto the byte stream feeding the UART transmitter. The frame matches the command frame: opcode, reserved, length LSB, length MSB, then payload bytes. Length counts all bytes, header included. Upstream and downstream both use valid/ready.

## Interface
- `MAX_BYTES_P`, default 8: maximum payload bytes per packet; sets the `data_i` width to 8*`MAX_BYTES_P`.
- `RSV_BYTE_P`, default 8'h00: value sent in the reserved header byte.

Clock and reset are one clock with a synchronous, active-high reset, named as the codebase does:
- `clk`  in  1: single clock; all state changes on posedge.
- `rst`  in  1: synchronous, active-high reset.

Upstream side (ALU/echo path):
- `opcode_i`  in  8: opcode echoed in header byte 0.
- `data_i`  in  8*MAX_BYTES_P: payload, little-endian; byte 0 = `data_i[7:0]` is sent first.
- `nbytes_i`  in  4: number of payload bytes, 0..MAX_BYTES_P.
- `valid_i`  in  1: upstream request valid.
- `ready_o`  out  1: packetizer can accept a request.

Downstream side (UART TX):
- `data_o`  out  8: byte to UART TX.
- `valid_o`  out  1: `data_o` valid.
- `ready_i`  in  1: UART TX accepts the byte.

Status:
- `done_o`  out  1: one-cycle pulse when the final byte of a packet is accepted.

## Operation
- States: IDLE, OP, RSV, LEN_LSB, LEN_MSB, PAYLOAD.
- **IDLE**
  - `ready_o`=1, `valid_o`=0.
  - On `valid_i`&&`ready_o`, latch `opcode_i`, `data_i` and the clamped count into internal registers, then go to OP.
  - Clamping: `nbytes_i` > `MAX_BYTES_P` is treated as `MAX_BYTES_P`.
- **Per-state output:**
  - OP: `data_o`=latched opcode.
  - RSV: `data_o`=`RSV_BYTE_P`.
  - LEN_LSB: `data_o`=`len[7:0]`.
  - LEN_MSB: `data_o`=`len[15:8]`.
  - `len` is 16 bits and equals latched count + 4, so it is always in 4..MAX_BYTES_P+4.
- **Advancing:** each state advances only on `valid_o`&&`ready_i`.
- **After LEN_MSB:**
  - Count 0: return to IDLE and pulse `done_o`.
  - Otherwise go to PAYLOAD.
- **PAYLOAD**
  - `data_o` = low byte of the payload shift register.
  - Each handshake shifts the register right by 8 and decrements the remaining count.
  - When the last byte is accepted, go to IDLE and pulse `done_o`.
- **Outside IDLE:** `ready_o`=0. Upstream requests are never dropped; they wait.
- `opcode_i` is passed through unchecked; the parser owns opcode validation.

## Timing
- **Reset values** while `rst`=1 and in the cycle after: state=IDLE, `valid_o`=0, `data_o`=8'h00, `done_o`=0.
  - `ready_o` is forced to 0 while `rst`=1 and is 1 from the first cycle after reset is released.
- **Latency:** request accepted in cycle T → `valid_o`=1 with the opcode byte in T+1.
- **Output registering:** `data_o` and `valid_o` are registered.
  - While `valid_o`=1 and `ready_i`=0, `data_o` is held stable and `valid_o` stays 1 (stall for any number of cycles).
- **Throughput:** with `ready_i` held at 1, a packet with N payload bytes takes 4+N consecutive `valid_o` cycles.
  - `ready_o` rises in the cycle after the final handshake. The minimum request-to-request spacing is 4+N+1 cycles.
- **`done_o` timing:** asserted in the cycle after the final handshake, coincident with `ready_o` rising.
- **Reset mid-packet:** the packet is abandoned, with no partial tail and no `done_o`. The next packet starts cleanly with its opcode byte.
- **Input stability:** upstream inputs are sampled only at acceptance; later changes to `opcode_i`/`data_i` have no effect.

## Test plan
- **Basic packet:** `opcode_i`=8'h01, `data_i`=64'h00000000_DEADBEEF, `nbytes_i`=4, `ready_i`=1.
  - Expect `data_o` = 01, 00, 08, 00, EF, BE, AD, DE on 8 consecutive cycles.
  - Expect `done_o` the cycle after the last byte, and `ready_o` low for 8 cycles.
- **Header-only:** `nbytes_i`=0, `opcode_i`=8'hEC.
  - Expect exactly 4 bytes: EC, 00, 04, 00.
  - Expect `done_o` after them and no PAYLOAD bytes.
- **Full width with stall:** `nbytes_i`=8, `data_i`=64'h8877665544332211, `ready_i` toggling 1/0 every cycle.
  - Expect 12 bytes ending 11,22,…,88, with header length byte 0C.
  - Expect `data_o` unchanged across every stalled cycle.
- **Clamp:** `nbytes_i`=13.
  - Expect length byte 0C and exactly 8 payload bytes.
- **Back-to-back:** `valid_i` held high with two different requests.
  - Expect the second to be accepted exactly when `ready_o` returns, and its opcode byte to follow one cycle later.
  - Expect no lost or duplicated bytes.
- **Reset mid-packet:** assert `rst` for 1 cycle during payload byte 2.
  - Expect `valid_o`=0 the next cycle, no `done_o`, and `ready_o`=1 after reset.
  - Expect a new request to produce a complete, correct packet.
